// File: rtl/taglist_pkg.sv
// Shared tag-entry field map, error codes and loader FSM encoding.
// The sequencer decodes entries with the same field constants.
package taglist_pkg;

  localparam int RSVD_HI   = 31;
  localparam int RSVD_LO   = 28;
  localparam int SEQ_ID_HI = 27;
  localparam int SEQ_ID_LO = 21;
  localparam int START_HI  = 20;
  localparam int START_LO  = 11;
  localparam int END_HI    = 10;
  localparam int END_LO    = 1;
  localparam int LAST_BIT  = 0;

  localparam int SEQ_W = SEQ_ID_HI - SEQ_ID_LO + 1;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_RANGE    = 2'd1;
  localparam logic [1:0] ERR_FIELD    = 2'd2;
  localparam logic [1:0] ERR_OVERFLOW = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_CHECK,
    ST_WRITE,
    ST_DONE,
    ST_ERROR
  } state_e;

endpackage

// File: rtl/taglist_loader_if.sv
// Byte-stream input and tag-list RAM write port of the loader.
interface taglist_loader_if #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 32
);
  logic              frame_start;
  logic              byte_valid;
  logic [7:0]        byte_data;
  logic              byte_ready;
  logic              taglist_wr;
  logic [ADDR_W-1:0] taglist_addr;
  logic [DATA_W-1:0] taglist_data;
  logic [ADDR_W-1:0] entry_count;
  logic              busy;
  logic              list_valid;
  logic [1:0]        load_error;

  modport master (
    output frame_start, byte_valid, byte_data,
    input  byte_ready, taglist_wr, taglist_addr, taglist_data,
           entry_count, busy, list_valid, load_error
  );

  modport slave (
    input  frame_start, byte_valid, byte_data,
    output byte_ready, taglist_wr, taglist_addr, taglist_data,
           entry_count, busy, list_valid, load_error
  );
endinterface

// File: rtl/tag_byte_assembler.sv
// Packs four little-endian bytes into one 32-bit tag entry.
// word_valid_o is combinational: it marks the cycle the fourth byte is taken.
module tag_byte_assembler (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clear_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_valid_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d  = 2'd0;
      word_d = '0;
    end else if (byte_en_i) begin
      word_d[{cnt_q, 3'b000} +: 8] = byte_i;
      cnt_d = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q  <= 2'd0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o       = word_q;
  assign word_valid_o = byte_en_i && (cnt_q == 2'd3);

endmodule

// File: rtl/taglist_loader.sv
// Assembles, validates and writes tag entries into the tag-list RAM;
// list_valid releases the sequencer once a last-flagged list is stored.
module taglist_loader
  import taglist_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 32,
  parameter int ROM_ADDR_W  = 10,
  parameter int MAX_ENTRIES = 128
) (
  input  logic             clock_n,
  input  logic             reset_n,
  taglist_loader_if.slave  bus
);

  localparam logic [ADDR_W-1:0] MAX_IDX = ADDR_W'(MAX_ENTRIES - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] index_q, index_d;
  logic [ADDR_W-1:0] count_q, count_d;
  logic [1:0]        err_q, err_d;

  logic [DATA_W-1:0]     word;
  logic                  word_valid;
  logic                  accept;
  logic                  wr;
  logic                  field_bad;
  logic                  range_bad;
  logic [SEQ_W-1:0]      seq_exp;
  logic [ROM_ADDR_W-1:0] start_f, end_f;

  assign accept = (state_q == ST_COLLECT) && !bus.frame_start && bus.byte_valid;

  tag_byte_assembler u_asm (
    .clk_i        (clock_n),
    .rst_n_i      (reset_n),
    .clear_i      (bus.frame_start),
    .byte_en_i    (accept),
    .byte_i       (bus.byte_data),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Seq ids are 7 bits wide, so the 128th entry of a full list carries id 0.
  assign seq_exp   = SEQ_W'(index_q) + SEQ_W'(1);
  assign start_f   = word[START_HI:START_LO];
  assign end_f     = word[END_HI:END_LO];
  assign field_bad = (|word[RSVD_HI:RSVD_LO]) || word[START_HI]
                     || (word[SEQ_ID_HI:SEQ_ID_LO] != seq_exp);
  assign range_bad = start_f > end_f;

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    count_d = count_q;
    err_d   = err_q;
    wr      = 1'b0;
    if (bus.frame_start) begin
      state_d = ST_COLLECT;
      index_d = '0;
      count_d = '0;
      err_d   = ERR_NONE;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_COLLECT: if (word_valid) state_d = ST_CHECK;
        ST_CHECK: begin
          if (field_bad) begin
            state_d = ST_ERROR;
            err_d   = ERR_FIELD;
          end else if (range_bad) begin
            state_d = ST_ERROR;
            err_d   = ERR_RANGE;
          end else begin
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: begin
          wr = 1'b1;
          // A full RAM cannot be counted in ADDR_W bits; overflow is reported by load_error.
          count_d = (index_q == MAX_IDX) ? index_q : index_q + 1'b1;
          if (word[LAST_BIT]) begin
            state_d = ST_DONE;
          end else if (index_q == MAX_IDX) begin
            state_d = ST_ERROR;
            err_d   = ERR_OVERFLOW;
          end else begin
            index_d = index_q + 1'b1;
            state_d = ST_COLLECT;
          end
        end
        ST_DONE, ST_ERROR: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_n or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      count_q <= '0;
      err_q   <= ERR_NONE;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign bus.byte_ready   = (state_q == ST_COLLECT) && !bus.frame_start;
  assign bus.taglist_wr   = wr;
  assign bus.taglist_addr = index_q;
  assign bus.taglist_data = word;
  assign bus.entry_count  = count_q;
  assign bus.busy         = (state_q == ST_COLLECT) || (state_q == ST_CHECK)
                            || (state_q == ST_WRITE);
  assign bus.list_valid   = (state_q == ST_DONE);
  assign bus.load_error   = err_q;

endmodule

// File: tb/tb_taglist_loader.sv
// Randomized and directed bench for taglist_loader against a list-level reference model.
module tb_taglist_loader;

  logic clock_n = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock_n = ~clock_n;

  taglist_loader_if bus ();

  taglist_loader dut (
    .clock_n (clock_n),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [6:0]  obs_addr[$];
  logic [31:0] obs_data[$];
  logic [31:0] lst[$];

  int         m_send, m_nwr;
  logic [1:0] m_err;
  bit         m_lv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock_n) begin
    if (bus.taglist_wr === 1'b1) begin
      obs_addr.push_back(bus.taglist_addr);
      obs_data.push_back(bus.taglist_data);
    end
  end

  function automatic logic [31:0] mk(input int seq, input int st, input int en, input bit last);
    return {4'b0000, 7'(seq), 10'(st), 10'(en), last};
  endfunction

  // List-level model: walk entries in order and stop at the first rejection.
  task automatic run_model();
    logic [31:0] e;
    m_send = 0; m_nwr = 0; m_err = 2'd0; m_lv = 1'b0;
    for (int i = 0; i < lst.size(); i++) begin
      e = lst[i];
      m_send = i + 1;
      if (e[31:28] != 4'd0 || e[20] || int'(e[27:21]) != (i + 1) % 128) begin
        m_err = 2'd2; break;
      end
      if (e[20:11] > e[10:1]) begin
        m_err = 2'd1; break;
      end
      m_nwr++;
      if (e[0]) begin
        m_lv = 1'b1; break;
      end
      if (i == 127) begin
        m_err = 2'd3; break;
      end
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      @(negedge clock_n); bus.byte_valid = 1'b0;
    end
    n = 0;
    @(negedge clock_n);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    while (bus.byte_ready !== 1'b1 && n < 100) begin
      @(negedge clock_n); n++;
    end
    if (n >= 100) chk("byte_ready_timeout", {63'd0, bus.byte_ready}, 64'd1);
    @(posedge clock_n);
  endtask

  task automatic send_entry(input logic [31:0] e, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(e[8*k +: 8], gaps);
  endtask

  task automatic pulse_frame();
    @(negedge clock_n);
    bus.byte_valid  = 1'b0;
    bus.frame_start = 1'b1;
    @(negedge clock_n);
    bus.frame_start = 1'b0;
    #1;
    obs_addr.delete();
    obs_data.delete();
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    @(negedge clock_n);
    bus.byte_valid = 1'b0;
    while (bus.busy === 1'b1 && n < 200) begin
      @(negedge clock_n); n++;
    end
    if (n >= 200) chk({tag, "_idle_timeout"}, {63'd0, bus.busy}, 64'd0);
    repeat (2) @(negedge clock_n);
  endtask

  task automatic check_result(input string tag);
    int ec;
    ec = (m_nwr > 127) ? 127 : m_nwr;
    chk({tag, "_nwr"}, obs_data.size(), m_nwr);
    for (int i = 0; i < m_nwr && i < obs_data.size(); i++) begin
      chk($sformatf("%s_addr%0d", tag, i), obs_addr[i], i);
      chk($sformatf("%s_data%0d", tag, i), obs_data[i], lst[i]);
    end
    chk({tag, "_count"}, bus.entry_count, ec);
    chk({tag, "_lv"}, bus.list_valid, m_lv);
    chk({tag, "_err"}, bus.load_error, m_err);
    chk({tag, "_busy"}, bus.busy, 0);
  endtask

  task automatic run_list(input string tag, input bit gaps);
    run_model();
    pulse_frame();
    for (int i = 0; i < m_send; i++) send_entry(lst[i], gaps);
    wait_idle(tag);
    check_result(tag);
  endtask

  task automatic five_list();
    lst.delete();
    lst.push_back(mk(1, 12'h000, 12'h005, 0));
    lst.push_back(mk(2, 12'h006, 12'h00c, 0));
    lst.push_back(mk(3, 12'h00d, 12'h015, 0));
    lst.push_back(mk(4, 12'h016, 12'h02a, 0));
    lst.push_back(mk(5, 12'h02b, 12'h03f, 1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_wr"}, bus.taglist_wr, 0);
    chk({tag, "_addr"}, bus.taglist_addr, 0);
    chk({tag, "_data"}, bus.taglist_data, 0);
    chk({tag, "_count"}, bus.entry_count, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_lv"}, bus.list_valid, 0);
    chk({tag, "_err"}, bus.load_error, 0);
    chk({tag, "_rdy"}, bus.byte_ready, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, st, en, kind, pos;
    bus.frame_start = 1'b0;
    bus.byte_valid  = 1'b0;
    bus.byte_data   = 8'h00;
    repeat (3) @(negedge clock_n);
    check_all_zero("reset");
    reset_n = 1'b1;
    @(negedge clock_n);

    // single entry with write-latency probe
    lst.delete();
    lst.push_back(mk(1, 3, 9, 1));
    run_model();
    pulse_frame();
    send_entry(lst[0], 1'b0);
    @(negedge clock_n);
    chk("lat_check_cycle", bus.taglist_wr, 0);
    @(negedge clock_n);
    chk("lat_write_cycle", bus.taglist_wr, 1);
    wait_idle("single");
    check_result("single");

    five_list();
    run_list("five", 1'b1);

    five_list();
    lst[2] = mk(3, 12'h020, 12'h010, 0);
    run_list("range", 1'b1);

    five_list();
    lst[1] = mk(7, 12'h006, 12'h00c, 0);
    run_list("seqid", 1'b0);

    five_list();
    lst[0] = lst[0] | 32'h8000_0000;
    run_list("rsvd", 1'b0);

    lst.delete();
    for (int i = 0; i < 128; i++) lst.push_back(mk((i + 1) % 128, i, i + 1, 0));
    run_list("ovf", 1'b0);

    // abort mid-entry, restart coincident with a byte
    five_list();
    pulse_frame();
    for (int i = 0; i < 3; i++) send_entry(lst[i], 1'b1);
    send_byte(lst[3][7:0], 1'b0);
    send_byte(lst[3][15:8], 1'b0);
    chk("abort_prior_writes", obs_data.size(), 3);
    @(negedge clock_n);
    bus.frame_start = 1'b1;
    bus.byte_valid  = 1'b1;
    bus.byte_data   = 8'haa;
    #1;
    chk("fs_byte_ready", bus.byte_ready, 0);
    @(negedge clock_n);
    bus.frame_start = 1'b0;
    bus.byte_valid  = 1'b0;
    #1;
    obs_addr.delete();
    obs_data.delete();
    lst.delete();
    lst.push_back(mk(1, 5, 6, 0));
    lst.push_back(mk(2, 7, 300, 1));
    run_model();
    for (int i = 0; i < m_send; i++) send_entry(lst[i], 1'b1);
    wait_idle("restart");
    check_result("restart");

    // reset during the write of entry 2
    five_list();
    pulse_frame();
    send_entry(lst[0], 1'b0);
    send_entry(lst[1], 1'b0);
    n = 0;
    while (!(bus.taglist_wr === 1'b1 && bus.taglist_addr == 7'd1) && n < 10) begin
      @(negedge clock_n); n++;
    end
    chk("rst_reach_write", {63'd0, bus.taglist_wr}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    bus.byte_valid = 1'b0;
    check_all_zero("midrst");
    @(negedge clock_n);
    reset_n = 1'b1;
    five_list();
    run_list("after_rst", 1'b1);

    for (int it = 0; it < 20; it++) begin
      lst.delete();
      len = $urandom_range(1, 10);
      for (int i = 0; i < len; i++) begin
        st = $urandom_range(0, 511);
        en = $urandom_range(st, 1023);
        lst.push_back(mk(i + 1, st, en, i == len - 1));
      end
      kind = $urandom_range(0, 4);
      pos  = $urandom_range(0, len - 1);
      case (kind)
        1: begin
          st = $urandom_range(1, 511);
          en = $urandom_range(0, st - 1);
          lst[pos] = mk(pos + 1, st, en, pos == len - 1);
        end
        2: lst[pos][27:21] = 7'(pos + 2);
        3: lst[pos][28 + $urandom_range(0, 3)] = 1'b1;
        4: lst[pos][20] = 1'b1;
        default: ;
      endcase
      run_list($sformatf("rnd%0d", it), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
